// File: rtl/lin_rx_frame_assembler.sv
// lin_rx_frame_assembler
// Collects the nine 10-bit UART symbols of a LIN response field (8 data
// symbols + 1 checksum symbol) into a 90-bit frame word for the checksum
// checker. A symbol with a bad start or stop bit aborts the partial frame,
// and so does an inter-byte timeout.
//
// Optional feature macro: LIN_RX_TIMEOUT_EN
//   defined   - the inter-byte timeout counter and timeout_error are built
//   undefined - no counter; timeout_error stays 0 and COLLECT waits forever
module lin_rx_frame_assembler #(
  parameter int NUM_SYM     = 9,
  parameter int TIMEOUT_CYC = 1400
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic                   frame_start,
  input  logic                   rx_sym_valid,
  input  logic [9:0]             rx_sym,
  output logic [NUM_SYM*10-1:0]  frame_data,
  output logic                   frame_valid,
  output logic                   framing_error,
  output logic                   timeout_error,
  output logic                   busy
);

  localparam int         FW       = NUM_SYM * 10;
  localparam logic [3:0] LAST_SYM = 4'(NUM_SYM - 1);

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

  state_t          state;
  logic [3:0]      sym_cnt;
  logic [FW-1:0]   shadow;
  logic [FW-1:0]   merged;
  logic            sym_ok;
  logic            sym_accept;
  logic            to_expire;

  // A symbol is well formed when its start bit is 0 and its stop bit is 1.
  assign sym_ok = ~rx_sym[0] & rx_sym[9];

  // frame_start always takes priority, so a symbol arriving with it is dropped.
  assign sym_accept = (state == COLLECT) && rx_sym_valid && !frame_start && sym_ok;

  // Shadow buffer with the incoming symbol placed in slot sym_cnt; this is
  // what frame_data receives when the final symbol lands.
  always_comb begin
    // NOTE: assign a full default first so no path through the loop leaves
    // merged unassigned, which would infer a latch.
    merged = shadow;
    for (int k = 0; k < NUM_SYM; k++) begin
      if (sym_cnt == 4'(k)) merged[k*10 +: 10] = rx_sym;
    end
  end

  // Shadow buffer write on every accepted symbol.
  // NOTE: the shadow buffer is storage, not control state, so it is not reset:
  // every slot is rewritten after each frame_start before it can reach frame_data.
  always_ff @(posedge PCLK) begin
    if (sym_accept) shadow <= merged;
  end

`ifdef LIN_RX_TIMEOUT_EN
  localparam int               TW     = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0]    TO_MAX = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] to_cnt;

  assign to_expire = (state == COLLECT) && (to_cnt == TO_MAX);

  // Inter-byte timeout counter: runs only while waiting for a symbol in COLLECT.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      to_cnt <= '0;
    end else if (frame_start || rx_sym_valid || state != COLLECT || to_expire) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  // No timeout hardware; the comparison is constant false and keeps the
  // TIMEOUT_CYC parameter referenced so both builds share one interface.
  assign to_expire = (TIMEOUT_CYC < 0);
`endif

  // Frame FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state         <= IDLE;
      sym_cnt       <= '0;
      frame_data    <= '0;
      frame_valid   <= 1'b0;
      framing_error <= 1'b0;
      timeout_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below sees
      // the register values from before this edge.
      frame_valid   <= 1'b0;
      framing_error <= 1'b0;
      timeout_error <= 1'b0;
      if (frame_start) begin
        // Arms collection, or silently restarts it if a frame was in progress.
        state   <= COLLECT;
        busy    <= 1'b1;
        sym_cnt <= '0;
      end else if (state == COLLECT) begin
        if (rx_sym_valid) begin
          if (!sym_ok) begin
            framing_error <= 1'b1;
            state         <= IDLE;
            busy          <= 1'b0;
            sym_cnt       <= '0;
          end else if (sym_cnt == LAST_SYM) begin
            frame_data  <= merged;
            frame_valid <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
            sym_cnt     <= '0;
          end else begin
            sym_cnt <= sym_cnt + 1'b1;
          end
        end else if (to_expire) begin
          timeout_error <= 1'b1;
          state         <= IDLE;
          busy          <= 1'b0;
          sym_cnt       <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_lin_rx_frame_assembler.sv
// Self-checking bench for lin_rx_frame_assembler. Directed steps drive
// frames; expected frame words go into a scoreboard queue and are compared
// when frame_valid pulses. Timeout steps follow the LIN_RX_TIMEOUT_EN build.
module tb_lin_rx_frame_assembler;

  localparam int TO = 20;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        frame_start = 1'b0;
  logic        rx_sym_valid = 1'b0;
  logic [9:0]  rx_sym = '0;
  logic [89:0] frame_data;
  logic        frame_valid;
  logic        framing_error;
  logic        timeout_error;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int fv_cnt = 0;
  int fe_cnt = 0;
  int to_cnt = 0;
  int n_frames = 0;
  int exp_to = 0;

  logic [89:0] exp_q[$];
  logic [9:0]  cur[9];
  logic [89:0] last_frame = '0;
  logic [9:0]  first_sym;

  lin_rx_frame_assembler #(
    .NUM_SYM    (9),
    .TIMEOUT_CYC(TO)
  ) dut (
    .PCLK         (PCLK),
    .PRESETn      (PRESETn),
    .frame_start  (frame_start),
    .rx_sym_valid (rx_sym_valid),
    .rx_sym       (rx_sym),
    .frame_data   (frame_data),
    .frame_valid  (frame_valid),
    .framing_error(framing_error),
    .timeout_error(timeout_error),
    .busy         (busy)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [89:0] obs, input logic [89:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Well-formed symbol: stop bit 1, data byte, start bit 0.
  function automatic logic [9:0] mk_sym(input logic [7:0] d);
    return {1'b1, d, 1'b0};
  endfunction

  function automatic logic [89:0] pack_cur();
    logic [89:0] f;
    f = '0;
    for (int k = 0; k < 9; k++) f[k*10 +: 10] = cur[k];
    return f;
  endfunction

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < 9; i++) cur[i] = mk_sym(base + 8'(i));
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic send(input logic [9:0] s);
    rx_sym       = s;
    rx_sym_valid = 1'b1;
    tick();
    rx_sym_valid = 1'b0;
  endtask

  task automatic start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic send_cur(input int from, input int upto);
    for (int i = from; i <= upto; i++) send(cur[i]);
  endtask

  task automatic expect_frame();
    exp_q.push_back(pack_cur());
    n_frames++;
    last_frame = pack_cur();
  endtask

  // Output monitor on the falling edge: scoreboard compare and pulse counting.
  always @(negedge PCLK) begin
    if (PRESETn) begin
      if (frame_valid) begin
        fv_cnt++;
        check("sb_nonempty", 90'(exp_q.size() != 0), 90'd1);
        if (exp_q.size() != 0) check("sb_frame", frame_data, exp_q.pop_front());
      end
      if (framing_error) fe_cnt++;
      if (timeout_error) to_cnt++;
      if (frame_valid || framing_error || timeout_error)
        check("one_pulse", 90'(frame_valid) + 90'(framing_error) + 90'(timeout_error), 90'd1);
    end
  end

  initial begin
    // Reset values
    tick();
    tick();
    check("rst_busy", 90'(busy), 90'd0);
    check("rst_frame_data", frame_data, 90'd0);
    check("rst_frame_valid", 90'(frame_valid), 90'd0);
    check("rst_framing_error", 90'(framing_error), 90'd0);
    check("rst_timeout_error", 90'(timeout_error), 90'd0);
    PRESETn = 1'b1;
    tick();

    // rx_sym_valid in IDLE is ignored
    send(10'h2FF);
    tick();
    check("idle_busy", 90'(busy), 90'd0);
    check("idle_pulses", 90'(fv_cnt + fe_cnt + to_cnt), 90'd0);

    // Good frame: data 01..08, checksum DB
    fill(8'h01);
    cur[8] = mk_sym(8'hDB);
    start();
    check("busy_rise", 90'(busy), 90'd1);
    expect_frame();
    send_cur(0, 7);
    check("good_busy_mid", 90'(busy), 90'd1);
    check("good_no_early_valid", 90'(frame_valid), 90'd0);
    send(cur[8]);
    check("good_valid", 90'(frame_valid), 90'd1);
    check("good_cksum_slot", 90'(frame_data[89:80]), 90'h3B6);
    check("good_slot0", 90'(frame_data[9:0]), 90'h202);
    check("good_busy_fall", 90'(busy), 90'd0);
    tick();
    check("good_valid_width", 90'(frame_valid), 90'd0);
    check("good_fv_cnt", 90'(fv_cnt), 90'd1);

    // Framing error: bad stop bit on the 4th symbol
    fill(8'h40);
    start();
    send_cur(0, 2);
    send(10'h002);
    check("fe_stop_pulse", 90'(framing_error), 90'd1);
    check("fe_busy", 90'(busy), 90'd0);
    check("fe_no_valid", 90'(frame_valid), 90'd0);
    check("fe_data_held", frame_data, last_frame);
    tick();
    check("fe_width", 90'(framing_error), 90'd0);

    // Framing error: bad start bit on the first symbol
    start();
    send(10'h203);
    check("fe_start_pulse", 90'(framing_error), 90'd1);
    check("fe_start_data_held", frame_data, last_frame);
    tick();

    // Restart mid-frame: partial frame discarded
    fill(8'h10);
    start();
    send_cur(0, 4);
    fill(8'h80);
    first_sym = cur[0];
    start();
    check("restart_busy", 90'(busy), 90'd1);
    expect_frame();
    send_cur(0, 8);
    check("restart_valid", 90'(frame_valid), 90'd1);
    check("restart_slot0", 90'(frame_data[9:0]), 90'(first_sym));
    tick();
    check("restart_fv_cnt", 90'(fv_cnt), 90'd2);

    // frame_start together with rx_sym_valid: symbol dropped
    fill(8'hA0);
    start();
    frame_start  = 1'b1;
    rx_sym       = 10'h3FE;
    rx_sym_valid = 1'b1;
    tick();
    frame_start  = 1'b0;
    rx_sym_valid = 1'b0;
    expect_frame();
    send_cur(0, 8);
    check("collide_valid", 90'(frame_valid), 90'd1);
    check("collide_data", frame_data, last_frame);

    // frame_start on the frame_valid cycle, then back-to-back frame
    fill(8'hC0);
    start();
    check("start_on_valid_busy", 90'(busy), 90'd1);
    expect_frame();
    send_cur(0, 8);
    check("b2b_valid", 90'(frame_valid), 90'd1);
    tick();

`ifdef LIN_RX_TIMEOUT_EN
    // Timeout after TO idle cycles following the last accepted symbol
    fill(8'h20);
    start();
    send_cur(0, 1);
    repeat (TO - 1) tick();
    check("to_not_yet", 90'(timeout_error), 90'd0);
    check("to_busy_before", 90'(busy), 90'd1);
    tick();
    check("to_pulse", 90'(timeout_error), 90'd1);
    check("to_busy_fall", 90'(busy), 90'd0);
    check("to_no_valid", 90'(frame_valid), 90'd0);
    exp_to++;
    tick();
    check("to_width", 90'(timeout_error), 90'd0);

    // Symbol on the expiry cycle wins
    fill(8'h30);
    start();
    send_cur(0, 1);
    repeat (TO - 1) tick();
    send(cur[2]);
    check("to_sym_wins", 90'(timeout_error), 90'd0);
    check("to_sym_busy", 90'(busy), 90'd1);
    expect_frame();
    send_cur(3, 8);
    check("to_recover_valid", 90'(frame_valid), 90'd1);
    tick();
`else
    // Without the timeout feature, COLLECT waits indefinitely
    fill(8'h20);
    start();
    send_cur(0, 1);
    repeat (3 * TO) tick();
    check("noto_busy", 90'(busy), 90'd1);
    check("noto_pulse", 90'(timeout_error), 90'd0);
    expect_frame();
    send_cur(2, 8);
    check("noto_valid", 90'(frame_valid), 90'd1);
    tick();
`endif

    // Asynchronous reset during COLLECT after 4 symbols
    fill(8'h50);
    start();
    send_cur(0, 3);
    PRESETn = 1'b0;
    #1;
    check("arst_busy", 90'(busy), 90'd0);
    check("arst_frame_data", frame_data, 90'd0);
    check("arst_pulses", 90'({frame_valid, framing_error, timeout_error}), 90'd0);
    #1;
    PRESETn = 1'b1;
    tick();
    fill(8'h60);
    start();
    expect_frame();
    send_cur(0, 8);
    check("post_rst_valid", 90'(frame_valid), 90'd1);
    check("post_rst_data", frame_data, last_frame);
    tick();
    tick();

    // Totals
    check("sb_drained", 90'(exp_q.size()), 90'd0);
    check("total_frames", 90'(fv_cnt), 90'(n_frames));
    check("total_framing_errors", 90'(fe_cnt), 90'd2);
    check("total_timeouts", 90'(to_cnt), 90'(exp_to));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
